disp_alert_sched: RTL

Scheduler for the 4-digit seven-segment display mux. It normally passes a background value through to the mux (e.g. a score or clock). An alert requester can borrow the display for a fixed hold time over a valid/ready handshake. During the hold the alert flashes, alternating with the background at a blink period. One further alert can be queued; the block drives the mux's hex3..hex0 and dp inputs directly.

---
 rtl/disp_pkg.sv | 24 ++
 rtl/disp_tick_gen.sv | 30 +++
 rtl/disp_alert_sched.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/disp_pkg.sv
// rtl/disp_pkg.sv - shared types and helpers for the display alert scheduler
package disp_pkg;

   localparam int NUM_DIGITS = 4;
   localparam int DIGIT_W    = 4;
   localparam int HEX_W      = NUM_DIGITS * DIGIT_W;

   typedef enum logic [1:0] {
      BG       = 2'd0,
      SHOW_ON  = 2'd1,
      SHOW_OFF = 2'd2
   } disp_state_t;

   typedef struct packed {
      logic [HEX_W-1:0]      hex;
      logic [NUM_DIGITS-1:0] dp;
   } disp_frame_t;

   // Counter width for a modulus; a modulus of 1 still needs one bit.
   function automatic int cnt_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/disp_tick_gen.sv
// rtl/disp_tick_gen.sv - clearable prescaler emitting a one-cycle tick
module disp_tick_gen
   import disp_pkg::*;
#(
   parameter int TICK_DIV = 100000
) (
   input  logic clk,
   input  logic reset,
   input  logic clr_i,
   output logic tick_o
);

   localparam int CW = cnt_w(TICK_DIV);
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt_q;

   assign tick_o = (cnt_q == LAST);

   always_ff @(posedge clk) begin
      if (reset || clr_i) begin
         cnt_q <= '0;
      end else if (tick_o) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

endmodule

// File: rtl/disp_alert_sched.sv
// rtl/disp_alert_sched.sv - arbitrates the 7-seg mux between background and timed blinking alerts
module disp_alert_sched
   import disp_pkg::*;
#(
   parameter int TICK_DIV    = 100000,
   parameter int HOLD_TICKS  = 2000,
   parameter int BLINK_TICKS = 250
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [HEX_W-1:0]      bg_hex,
   input  logic [NUM_DIGITS-1:0] bg_dp,
   input  logic                  alert_valid,
   output logic                  alert_ready,
   input  logic [HEX_W-1:0]      alert_hex,
   input  logic [NUM_DIGITS-1:0] alert_dp,
   input  logic                  alert_clear,
   output logic [DIGIT_W-1:0]    hex3,
   output logic [DIGIT_W-1:0]    hex2,
   output logic [DIGIT_W-1:0]    hex1,
   output logic [DIGIT_W-1:0]    hex0,
   output logic [NUM_DIGITS-1:0] dp_out,
   output logic                  busy
);

   localparam int HW = cnt_w(HOLD_TICKS);
   localparam int BW = cnt_w(BLINK_TICKS);
   localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_TICKS - 1);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);

   disp_state_t   state_q, state_d;
   disp_frame_t   cur_q, cur_d;
   disp_frame_t   pend_q, pend_d;
   logic          pend_valid_q, pend_valid_d;
   logic [HW-1:0] hold_cnt_q, hold_cnt_d;
   logic [BW-1:0] blink_cnt_q, blink_cnt_d;
   disp_frame_t   out_q, out_d;
   logic          busy_q;

   disp_frame_t   bg_frame, alert_frame;
   logic          accept;
   logic          load;
   logic          tick;
   logic          expiry;

   assign bg_frame    = '{hex: bg_hex, dp: bg_dp};
   assign alert_frame = '{hex: alert_hex, dp: alert_dp};

   assign alert_ready = !pend_valid_q && !alert_clear && !reset;
   assign accept      = alert_valid && alert_ready;
   assign expiry      = tick && (hold_cnt_q == HOLD_LAST) && (state_q != BG);

   // Restarting the prescaler on every load keeps each alert's phases whole ticks long.
   disp_tick_gen #(
      .TICK_DIV(TICK_DIV)
   ) u_tick_gen (
      .clk   (clk),
      .reset (reset),
      .clr_i (load),
      .tick_o(tick)
   );

   always_comb begin
      state_d      = state_q;
      cur_d        = cur_q;
      pend_d       = pend_q;
      pend_valid_d = pend_valid_q;
      hold_cnt_d   = hold_cnt_q;
      blink_cnt_d  = blink_cnt_q;
      load         = 1'b0;

      if (alert_clear) begin
         state_d      = BG;
         pend_valid_d = 1'b0;
         load         = 1'b1;
      end else if (state_q == BG) begin
         if (accept) begin
            cur_d   = alert_frame;
            state_d = SHOW_ON;
            load    = 1'b1;
         end
      end else if (expiry) begin
         // Chain straight into the next alert so the display never flashes background between them.
         if (pend_valid_q) begin
            cur_d        = pend_q;
            pend_valid_d = 1'b0;
            state_d      = SHOW_ON;
            load         = 1'b1;
         end else if (accept) begin
            cur_d   = alert_frame;
            state_d = SHOW_ON;
            load    = 1'b1;
         end else begin
            state_d = BG;
            load    = 1'b1;
         end
      end else begin
         if (accept) begin
            pend_d       = alert_frame;
            pend_valid_d = 1'b1;
         end
         if (tick) begin
            hold_cnt_d = hold_cnt_q + 1'b1;
            if (blink_cnt_q == BLINK_LAST) begin
               blink_cnt_d = '0;
               state_d     = (state_q == SHOW_ON) ? SHOW_OFF : SHOW_ON;
            end else begin
               blink_cnt_d = blink_cnt_q + 1'b1;
            end
         end
      end

      if (load) begin
         hold_cnt_d  = '0;
         blink_cnt_d = '0;
      end

      out_d = (state_d == SHOW_ON) ? cur_d : bg_frame;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= BG;
         cur_q        <= '0;
         pend_q       <= '0;
         pend_valid_q <= 1'b0;
         hold_cnt_q   <= '0;
         blink_cnt_q  <= '0;
         out_q        <= '0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cur_q        <= cur_d;
         pend_q       <= pend_d;
         pend_valid_q <= pend_valid_d;
         hold_cnt_q   <= hold_cnt_d;
         blink_cnt_q  <= blink_cnt_d;
         out_q        <= out_d;
         busy_q       <= (state_d != BG);
      end
   end

   assign hex3   = out_q.hex[4*DIGIT_W-1:3*DIGIT_W];
   assign hex2   = out_q.hex[3*DIGIT_W-1:2*DIGIT_W];
   assign hex1   = out_q.hex[2*DIGIT_W-1:DIGIT_W];
   assign hex0   = out_q.hex[DIGIT_W-1:0];
   assign dp_out = out_q.dp;
   assign busy   = busy_q;

endmodule
